clause_programmer: RTL

//  Write-side driver for the clause-column array SRAM programming interface.

---
 rtl/clause_programmer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/clause_programmer.sv
// clause_programmer: loads one clause record (two literals, unit flag, SI bit) into one
// column of the clause array by sequencing the word-line / bit-line programming cycles.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a record, CL_READY high
// CLR   | all variable rows selected, enables of the target column cleared
// ROWL  | left-literal row written (also right enable when indices match)
// ROWR  | right-literal row written (skipped for unit or repeated index)
// SIGN  | sign row written: SI bit and literal polarities
// DONE  | PROG_DONE pulse, clause counter advanced
module clause_programmer #(
  parameter int NVAR = 60,
  parameter int NCOL = 16,
  parameter int IDXW = 6,
  parameter int COLW = 4,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            CL_VALID,
  output logic            CL_READY,
  input  logic [COLW-1:0] CL_COL,
  input  logic [IDXW-1:0] CL_IDX_L,
  input  logic [IDXW-1:0] CL_IDX_R,
  input  logic            CL_NEG_L,
  input  logic            CL_NEG_R,
  input  logic            CL_UNIT,
  input  logic            CL_SI,
  output logic [NVAR-1:0] WL_SW,
  output logic            WL_SIGN,
  output logic [NCOL-1:0] BL_EN,
  output logic            BL_SI,
  output logic            BL_SL,
  output logic            BL_SR,
  output logic            SRAM_STATE,
  output logic            PROG_DONE,
  output logic            PROG_ERR,
  output logic [CNTW-1:0] CLAUSE_CNT
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_ROWL = 3'd2,
    S_ROWR = 3'd3,
    S_SIGN = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [COLW:0]   NCOL_L  = (COLW+1)'(NCOL);
  localparam logic [IDXW:0]   NVAR_L  = (IDXW+1)'(NVAR);
  localparam logic [NVAR-1:0] ONE_VAR = {{(NVAR-1){1'b0}}, 1'b1};
  localparam logic [NCOL-1:0] ONE_COL = {{(NCOL-1){1'b0}}, 1'b1};

  state_t          state, state_nx;
  logic [COLW-1:0] col_q, col_nx;
  logic [IDXW-1:0] idx_l_q, idx_l_nx;
  logic [IDXW-1:0] idx_r_q, idx_r_nx;
  logic            neg_l_q, neg_l_nx;
  logic            neg_r_q, neg_r_nx;
  logic            unit_q, unit_nx;
  logic            si_q, si_nx;

  logic            accept;
  logic            bad_rec;
  logic            err_nx;
  logic            same_idx_q;

  logic [NVAR-1:0] wl_sw_nx;
  logic            wl_sign_nx;
  logic [NCOL-1:0] bl_en_nx;
  logic            bl_si_nx;
  logic            bl_sl_nx;
  logic            bl_sr_nx;
  logic            done_nx;

  assign accept     = CL_VALID & CL_READY;
  assign same_idx_q = (idx_r_q == idx_l_q);

  // The right index only matters when the clause actually has a right literal.
  assign bad_rec = ({1'b0, CL_COL} >= NCOL_L) ||
                   ({1'b0, CL_IDX_L} >= NVAR_L) ||
                   (!CL_UNIT && ({1'b0, CL_IDX_R} >= NVAR_L));

  always_comb begin
    state_nx = state;
    col_nx   = col_q;
    idx_l_nx = idx_l_q;
    idx_r_nx = idx_r_q;
    neg_l_nx = neg_l_q;
    neg_r_nx = neg_r_q;
    unit_nx  = unit_q;
    si_nx    = si_q;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          col_nx   = CL_COL;
          idx_l_nx = CL_IDX_L;
          idx_r_nx = CL_IDX_R;
          neg_l_nx = CL_NEG_L;
          neg_r_nx = CL_NEG_R;
          unit_nx  = CL_UNIT;
          si_nx    = CL_SI;
          if (bad_rec) err_nx = 1'b1;
          else         state_nx = S_CLR;
        end
      end
      S_CLR:   state_nx = S_ROWL;
      S_ROWL:  state_nx = (unit_q || same_idx_q) ? S_SIGN : S_ROWR;
      S_ROWR:  state_nx = S_SIGN;
      S_SIGN:  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they register with it.
  always_comb begin
    wl_sw_nx   = '0;
    wl_sign_nx = 1'b0;
    bl_en_nx   = '0;
    bl_si_nx   = 1'b0;
    bl_sl_nx   = 1'b0;
    bl_sr_nx   = 1'b0;
    done_nx    = 1'b0;
    case (state_nx)
      S_CLR: begin
        wl_sw_nx = '1;
        bl_en_nx = ONE_COL << col_nx;
      end
      S_ROWL: begin
        wl_sw_nx = ONE_VAR << idx_l_nx;
        bl_en_nx = ONE_COL << col_nx;
        bl_sl_nx = 1'b1;
        bl_sr_nx = !unit_nx && (idx_r_nx == idx_l_nx);
      end
      S_ROWR: begin
        wl_sw_nx = ONE_VAR << idx_r_nx;
        bl_en_nx = ONE_COL << col_nx;
        bl_sr_nx = 1'b1;
      end
      S_SIGN: begin
        // A unit clause stores a right sign that makes the absent term read as false.
        wl_sign_nx = 1'b1;
        bl_en_nx   = ONE_COL << col_nx;
        bl_si_nx   = si_nx;
        bl_sl_nx   = ~neg_l_nx;
        bl_sr_nx   = unit_nx ? 1'b1 : ~neg_r_nx;
      end
      S_DONE: done_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      col_q      <= '0;
      idx_l_q    <= '0;
      idx_r_q    <= '0;
      neg_l_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      unit_q     <= 1'b0;
      si_q       <= 1'b0;
      CL_READY   <= 1'b0;
      WL_SW      <= '0;
      WL_SIGN    <= 1'b0;
      BL_EN      <= '0;
      BL_SI      <= 1'b0;
      BL_SL      <= 1'b0;
      BL_SR      <= 1'b0;
      SRAM_STATE <= 1'b0;
      PROG_DONE  <= 1'b0;
      PROG_ERR   <= 1'b0;
      CLAUSE_CNT <= '0;
    end else begin
      state      <= state_nx;
      col_q      <= col_nx;
      idx_l_q    <= idx_l_nx;
      idx_r_q    <= idx_r_nx;
      neg_l_q    <= neg_l_nx;
      neg_r_q    <= neg_r_nx;
      unit_q     <= unit_nx;
      si_q       <= si_nx;
      CL_READY   <= (state_nx == S_IDLE);
      WL_SW      <= wl_sw_nx;
      WL_SIGN    <= wl_sign_nx;
      BL_EN      <= bl_en_nx;
      BL_SI      <= bl_si_nx;
      BL_SL      <= bl_sl_nx;
      BL_SR      <= bl_sr_nx;
      SRAM_STATE <= (state_nx != S_IDLE);
      PROG_DONE  <= done_nx;
      PROG_ERR   <= err_nx;
      if (state == S_SIGN) CLAUSE_CNT <= CLAUSE_CNT + 1'b1;
    end
  end

endmodule
